// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_e       : frame FSM states
//   PAR_EVEN/PAR_ODD : encodings of the PAR_TYP input
//   PRESCALE_8/16/32 : legal clocks-per-bit settings
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-sample majority voter for one serial bit.
//   clk, rst          : clock, asynchronous active-high reset
//   rx_i              : synchronised serial line
//   edge_count_i      : position within the current bit period
//   half_prescale_i   : half of the latched clocks-per-bit value (h)
//   sampled_bit_o     : majority of the samples taken at h-1, h, h+1
//   decision_o        : high in the cycle at edge h+2, when sampled_bit_o is final
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    input  logic [PRESCALE_W-1:0] edge_count_i,
    input  logic [PRESCALE_W-1:0] half_prescale_i,
    output logic                  sampled_bit_o,
    output logic                  decision_o
);

    logic [2:0]            samp_q, samp_d;
    logic [PRESCALE_W-1:0] half_m1, half_p1, half_p2;

    assign half_m1 = half_prescale_i - PRESCALE_W'(1);
    assign half_p1 = half_prescale_i + PRESCALE_W'(1);
    assign half_p2 = half_prescale_i + PRESCALE_W'(2);

    always_comb begin
        samp_d = samp_q;
        if (edge_count_i == half_m1)         samp_d[0] = rx_i;
        if (edge_count_i == half_prescale_i) samp_d[1] = rx_i;
        if (edge_count_i == half_p1)         samp_d[2] = rx_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q <= '0;
        end else begin
            samp_q <= samp_d;
        end
    end

    assign sampled_bit_o = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                           (samp_q[1] & samp_q[2]);
    assign decision_o    = (edge_count_i == half_p2);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserialisation,
// parity and stop checking, registered result pulses.
//   clk, rst               : clock, asynchronous active-high reset
//   RX_IN                  : synchronised serial line, idle high
//   PAR_EN, PAR_TYP        : parity enable / type (0 even, 1 odd)
//   Prescale               : clocks per bit (8, 16 or 32)
//   Bit_count, Edge_count  : position from the external edge/bit counter
//   cnt_en                 : enable for that counter (high outside IDLE)
//   P_DATA                 : last good received byte
//   data_valid             : one-cycle pulse when P_DATA updates
//   par_err, stp_err       : one-cycle error pulses
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [3:0]            Bit_count,
    input  logic [PRESCALE_W-1:0] Edge_count,
    output logic                  cnt_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [3:0] LastDataBit = 4'(DATA_WIDTH);

    rx_state_e             state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  par_fail_q, par_fail_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic [PRESCALE_W-1:0] half_prescale;
    logic                  sampled_bit;
    logic                  decision;

    assign half_prescale = prescale_q >> 1;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk             (clk),
        .rst             (rst),
        .rx_i            (RX_IN),
        .edge_count_i    (Edge_count),
        .half_prescale_i (half_prescale),
        .sampled_bit_o   (sampled_bit),
        .decision_o      (decision)
    );

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        par_fail_d   = par_fail_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        prescale_d   = prescale_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A line stuck low after a stop error must go high before re-arming.
                if (RX_IN) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = StStart;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    prescale_d = Prescale;
                    par_fail_d = 1'b0;
                end
            end
            StStart: begin
                if (decision) begin
                    state_d = sampled_bit ? StIdle : StData;
                end
            end
            StData: begin
                if (decision) begin
                    // Right shift: the first data bit ends up in the LSB.
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (Bit_count == LastDataBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (decision) begin
                    if (sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD))) begin
                        par_err_d  = 1'b1;
                        par_fail_d = 1'b1;
                    end
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leaving at mid-stop lets a back-to-back start bit be caught.
                if (decision) begin
                    state_d = StIdle;
                    if (sampled_bit) begin
                        if (!par_fail_q) begin
                            p_data_d     = shift_q;
                            data_valid_d = 1'b1;
                        end
                    end else begin
                        stp_err_d = 1'b1;
                        armed_d   = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            armed_q      <= 1'b1;
            par_fail_q   <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            prescale_q   <= PRESCALE_W'(PRESCALE_8);
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            par_fail_q   <= par_fail_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            prescale_q   <= prescale_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign cnt_en     = (state_q != StIdle);
    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: includes a model of the edge/bit counter, drives serial
// frames, and checks outcomes against a table and against a frame-level model.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] Prescale;
    logic [3:0]    Bit_count;
    logic [PW-1:0] Edge_count;
    logic          cnt_en;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .Bit_count  (Bit_count),
        .Edge_count (Edge_count),
        .cnt_en     (cnt_en),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    // Edge/bit counter environment: holds 0 while disabled, latches its own prescale then.
    logic [PW-1:0] cnt_p;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            Edge_count <= '0;
            Bit_count  <= '0;
            cnt_p      <= PW'(PRESCALE_8);
        end else if (!cnt_en) begin
            Edge_count <= '0;
            Bit_count  <= '0;
            cnt_p      <= Prescale;
        end else if (Edge_count == cnt_p - PW'(1)) begin
            Edge_count <= '0;
            Bit_count  <= Bit_count + 4'd1;
        end else begin
            Edge_count <= Edge_count + PW'(1);
        end
    end

    // Pulse monitor, sampled 1 time unit after the rising edge.
    int   cyc = 0, dv_cnt = 0, pe_cnt = 0, se_cnt = 0, start_cyc = 0, dv_cyc = 0;
    logic en_prev = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            if (cnt_en && !en_prev) start_cyc = cyc;
            if (data_valid) begin
                dv_cnt++;
                dv_cyc = cyc;
            end
            if (par_err) pe_cnt++;
            if (stp_err) se_cnt++;
        end
        en_prev = cnt_en;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; flip >= 0 inverts that line cycle inside every data bit.
    task automatic send_frame(input logic [7:0] data, input bit pen, input bit ptyp,
                              input int p, input bit par_bit, input bit stop_v,
                              input int flip, input bit scramble, input int nbits);
        logic [11:0] bits;
        int          n;
        logic        v;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        n = 9;
        if (pen) begin
            bits[n] = par_bit;
            n++;
        end
        bits[n] = stop_v;
        n++;
        if (nbits > 0 && nbits < n) n = nbits;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                v = bits[b];
                if (b >= 1 && b <= 8 && c == flip) v = ~v;
                RX_IN = v;
                if (b == 0 && c == 0) begin
                    PAR_EN   = pen;
                    PAR_TYP  = ptyp;
                    Prescale = PW'(p);
                end else if (b == 0 && c == 1 && scramble) begin
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                    Prescale = PW'(8 << $urandom_range(0, 2));
                end
            end
        end
    endtask

    task automatic frame_check(input string name, input logic [7:0] data, input bit pen,
                               input bit ptyp, input int p, input bit par_bit,
                               input bit stop_v, input int flip, input bit scramble,
                               input int gap, input int e_dv, input int e_pe,
                               input int e_se, input logic [7:0] e_pdata);
        int dv0, pe0, se0;
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        se0 = se_cnt;
        send_frame(data, pen, ptyp, p, par_bit, stop_v, flip, scramble, -1);
        idle(gap);
        check({name, "_dv"}, 32'(dv_cnt - dv0), 32'(e_dv));
        check({name, "_pe"}, 32'(pe_cnt - pe0), 32'(e_pe));
        check({name, "_se"}, 32'(se_cnt - se0), 32'(e_se));
        check({name, "_pdata"}, 32'(P_DATA), 32'(e_pdata));
    endtask

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         ptyp;
        int         p;
        bit         par_bit;
        bit         stop;
        int         flip;
        int         dv;
        int         pe;
        int         se;
        logic [7:0] pdata;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int         dv0, pe0, se0, low_en, p, k, flip, gap;
        logic [7:0] data, exp_pdata;
        bit         pen, ptyp, par_bit, stop_v, scr, mism, e_dv;

        tbl[0] = '{8'hA5, 0, PAR_EVEN, 8,  0, 1, -1, 1, 0, 0, 8'hA5};
        tbl[1] = '{8'h3C, 1, PAR_EVEN, 16, 0, 1, -1, 1, 0, 0, 8'h3C};
        tbl[2] = '{8'h5A, 0, PAR_EVEN, 8,  0, 1, 5,  1, 0, 0, 8'h5A};
        tbl[3] = '{8'h3C, 1, PAR_EVEN, 16, 1, 1, -1, 0, 1, 0, 8'h5A};
        tbl[4] = '{8'h96, 1, PAR_ODD,  32, 1, 1, -1, 1, 0, 0, 8'h96};
        tbl[5] = '{8'hC3, 0, PAR_EVEN, 16, 0, 1, 8,  1, 0, 0, 8'hC3};
        tbl[6] = '{8'h00, 0, PAR_EVEN, 32, 0, 0, -1, 0, 0, 1, 8'hC3};
        tbl[7] = '{8'h01, 1, PAR_EVEN, 8,  0, 0, -1, 0, 1, 1, 8'hC3};

        rst      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = PW'(PRESCALE_8);
        repeat (3) @(negedge clk);
        check("reset_state", 32'({cnt_en, P_DATA, data_valid, par_err, stp_err}), 32'd0);
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 8; i++) begin
            frame_check($sformatf("tbl%0d", i), tbl[i].data, tbl[i].pen, tbl[i].ptyp,
                        tbl[i].p, tbl[i].par_bit, tbl[i].stop, tbl[i].flip, 1'b0, 3,
                        tbl[i].dv, tbl[i].pe, tbl[i].se, tbl[i].pdata);
            if (i == 0) check("dv_latency", 32'(dv_cyc - start_cyc), 32'd79);
        end

        // Start-bit glitch: low only through counter edges 0..2.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        @(negedge clk);
        RX_IN    = 1'b0;
        PAR_EN   = 1'b0;
        Prescale = PW'(PRESCALE_8);
        repeat (3) begin
            @(negedge clk);
            RX_IN = 1'b0;
        end
        check("glitch_in_start", 32'(cnt_en), 32'd1);
        idle(8);
        check("glitch_idle", 32'(cnt_en), 32'd0);
        check("glitch_pulses", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

        // Stop error, line then held low: no restart until it goes high.
        dv0 = dv_cnt; se0 = se_cnt;
        send_frame(8'hFF, 0, PAR_EVEN, 8, 0, 0, -1, 0, -1);
        low_en = 0;
        repeat (20) begin
            @(negedge clk);
            RX_IN = 1'b0;
            if (cnt_en) low_en++;
        end
        check("stperr_se", 32'(se_cnt - se0), 32'd1);
        check("stperr_dv", 32'(dv_cnt - dv0), 32'd0);
        check("stperr_no_restart", 32'(low_en), 32'd0);
        idle(2);
        frame_check("after_stperr", 8'h12, 0, PAR_EVEN, 8, 0, 1, -1, 0, 3, 1, 0, 0, 8'h12);

        // Back-to-back frames with no idle gap.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h3A, 0, PAR_EVEN, 8, 0, 1, -1, 0, -1);
        send_frame(8'hC5, 0, PAR_EVEN, 8, 0, 1, -1, 0, -1);
        idle(3);
        check("b2b_dv", 32'(dv_cnt - dv0), 32'd2);
        check("b2b_err", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
        check("b2b_pdata", 32'(P_DATA), 32'hC5);

        // Reset in the middle of the data bits.
        send_frame(8'h77, 0, PAR_EVEN, 8, 0, 1, -1, 0, 4);
        @(negedge clk);
        rst   = 1'b1;
        RX_IN = 1'b1;
        @(negedge clk);
        check("midreset_outputs", 32'({cnt_en, P_DATA, data_valid, par_err, stp_err}), 32'd0);
        rst = 1'b0;
        idle(3);
        frame_check("after_reset", 8'h81, 0, PAR_EVEN, 8, 0, 1, -1, 0, 3, 1, 0, 0, 8'h81);

        // Randomised frames against a frame-level outcome model.
        exp_pdata = 8'h81;
        for (int n = 0; n < 40; n++) begin
            data    = 8'($urandom);
            pen     = 1'($urandom);
            ptyp    = 1'($urandom);
            par_bit = 1'($urandom);
            stop_v  = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 2))
                0:       p = PRESCALE_8;
                1:       p = PRESCALE_16;
                default: p = PRESCALE_32;
            endcase
            k    = $urandom_range(0, 3);
            flip = (k == 0) ? -1 : (p / 2 + k - 1);
            scr  = 1'($urandom);
            gap  = $urandom_range(2, 5);
            mism = pen && (par_bit != ((^data) ^ ptyp));
            e_dv = stop_v && !mism;
            if (e_dv) exp_pdata = data;
            frame_check($sformatf("rnd%0d", n), data, pen, ptyp, p, par_bit, stop_v, flip,
                        scr, gap, int'(e_dv), int'(mism), int'(!stop_v), exp_pdata);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side frame controller for the UART RX path. It sits directly downstream of the edge/bit counter, consuming its Bit_count/Edge_count and driving its enable. It detects the start bit and takes a 3-sample majority vote per bit. It deserializes the frame LSB-first, checks parity and stop, and presents a received byte with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of Prescale and Edge_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
RX_IN  input  1  serial line, already synchronised to clk, idle high
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESCALE_W  clocks per bit; legal values are 8, 16 and 32
Bit_count  input  4  from the edge/bit counter
Edge_count  input  PRESCALE_W  from the edge/bit counter
cnt_en  output  1  enable to the edge/bit counter
P_DATA  output  DATA_WIDTH  last good received byte
data_valid  output  1  one-cycle pulse when P_DATA updates
par_err  output  1  one-cycle pulse on parity mismatch
stp_err  output  1  one-cycle pulse on stop bit sampled 0

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state = IDLE, cnt_en = 0, P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0.
  - Shift register and sample flops are cleared. armed = 1.
- States: IDLE, START, DATA, PARITY, STOP. cnt_en = 1 in every state except IDLE (Moore output).
- Counter contract:
  - The counter holds 0 while cnt_en = 0.
  - Edge_count runs 0..Prescale-1. Bit_count increments when Edge_count wraps.
  - Frame bit index: 0 = start, 1..DATA_WIDTH = data, DATA_WIDTH+1 = parity (if enabled), last = stop.
- Config latch: PAR_EN, PAR_TYP and Prescale are captured on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
- Sampling (h = Prescale_latched/2):
  - RX_IN is captured at Edge_count = h-1, h and h+1.
  - The majority of the three samples is the bit value, used when Edge_count = h+2 (the "decision cycle").
  - For Prescale = 8: samples at 3, 4, 5; decision at 6.
- IDLE:
  - If armed = 1 and RX_IN = 0, go to START on the next edge.
  - armed is set when RX_IN = 1 is seen in IDLE. It is cleared after a stop error.
- START, at decision:
  - Bit = 0: go to DATA.
  - Bit = 1 (glitch): go to IDLE with no pulses.
- DATA, at decision:
  - Shift the bit in LSB-first (bit index Bit_count-1).
  - When Bit_count = DATA_WIDTH, go to PARITY if PAR_EN, else to STOP.
- PARITY, at decision:
  - Expected bit = XOR(data) for even, ~XOR(data) for odd.
  - On mismatch, par_err pulses for 1 cycle and a parity-fail flag is set.
  - Go to STOP.
- STOP, at decision (always go to IDLE, which drops cnt_en and clears the counter):
  - Bit = 1 and no parity fail: P_DATA <= shift register, data_valid = 1 for exactly 1 cycle.
  - Bit = 1 with parity fail: no data_valid, P_DATA is unchanged.
  - Bit = 0: stp_err pulses for 1 cycle, no data_valid, armed = 0.
- Output timing: all outputs are registered. Pulses are high in the cycle after the decision cycle.
- Back-to-back frames: returning to IDLE at mid-stop lets the next falling edge be caught with no gap.
- P_DATA holds its value until the next good frame.

Decomposition:
- Shared package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP), PAR_EVEN/PAR_ODD constants, and the legal Prescale values.
- One sub-module, uart_rx_sampler: three sample flops and a majority vote. Inputs: RX_IN, Edge_count, half-prescale. Outputs: sampled_bit and decision strobe.

Test Plan:
- Prescale = 8, PAR_EN = 0, frame 0xA5 -> data_valid high exactly at cycle 79 after START entry, P_DATA = 0xA5, no errors.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity bit 0 -> P_DATA = 0x3C, par_err = 0. Same frame with parity bit 1 -> par_err pulses once, no data_valid, P_DATA keeps its previous value.
- Prescale = 8, RX_IN low only for edges 0..2 of the start bit -> return to IDLE, cnt_en drops, no pulses.
- Prescale = 8, byte 0xFF with stop bit 0, line held low -> stp_err pulses once. No new frame starts until RX_IN returns to 1, then frame 0x12 is received correctly.
- Prescale = 8, one sample flipped per data bit (e.g. at edge 4) -> majority vote recovers 0x5A.
- Assert rst during DATA of frame 0x77, release, send frame 0x81 -> all outputs 0 during reset, then P_DATA = 0x81 with a single data_valid.
